// File: rtl/rf_exec_pkg.sv
// -----------------------------------------------------------------------------
// rf_exec_pkg
// Shared definitions for the register-file execution controller:
//   - DW_DEF / AW_DEF : default data width and register address width
//   - OP_*            : 4-bit opcode constants
//   - state_e         : controller FSM state encoding
//   - wb_hi_addr()    : destination of the high product half (rd + 1, wraps)
// Optional feature macro: RF_EXEC_MUL_EN (enables the opcode 8 multiply).
// -----------------------------------------------------------------------------
package rf_exec_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // High product half lands in the register after rd, wrapping at the top
  function automatic logic [AW_DEF-1:0] wb_hi_addr(input logic [AW_DEF-1:0] rd);
    wb_hi_addr = rd + {{(AW_DEF-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rf_exec_if.sv
// -----------------------------------------------------------------------------
// rf_exec_if
// Instruction-issue handshake between an instruction source and the
// controller. An instruction is accepted when IN_VALID and IN_READY are both
// high at the clock edge.
//   IN_VALID  : instruction offered           (master -> slave)
//   IN_READY  : controller can accept          (slave  -> master)
//   IN_OP     : 4-bit opcode                   (master -> slave)
//   IN_RD     : destination register           (master -> slave)
//   IN_RS1    : source A register              (master -> slave)
//   IN_RS2    : source B register              (master -> slave)
// -----------------------------------------------------------------------------
interface rf_exec_if #(
  parameter int AW = rf_exec_pkg::AW_DEF
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [3:0]    IN_OP;
  logic [AW-1:0] IN_RD;
  logic [AW-1:0] IN_RS1;
  logic [AW-1:0] IN_RS2;

  modport master (
    output IN_VALID, IN_OP, IN_RD, IN_RS1, IN_RS2,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID, IN_OP, IN_RD, IN_RS1, IN_RS2,
    output IN_READY
  );
endinterface

// File: rtl/rf_exec_alu.sv
// -----------------------------------------------------------------------------
// rf_exec_alu
// Purely combinational arithmetic for the execution controller.
//   i_op    : opcode
//   i_a     : operand A (from rs1)
//   i_b     : operand B (from rs2); shifts use only i_b[3:0]
//   o_lo    : result (low product half for multiply)
//   o_we_a  : opcode writes the primary port
//   o_hi    : high product half          (only with RF_EXEC_MUL_EN)
//   o_we_b  : opcode writes secondary port (only with RF_EXEC_MUL_EN)
// Without RF_EXEC_MUL_EN no multiplier exists and opcode 8 is a no-op.
// -----------------------------------------------------------------------------
module rf_exec_alu
  import rf_exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_lo,
`ifdef RF_EXEC_MUL_EN
  output logic [DW-1:0] o_hi,
  output logic          o_we_b,
`endif
  output logic          o_we_a
);

`ifdef RF_EXEC_MUL_EN
  logic [2*DW-1:0] w_prod;

  // Zero-extended so the product is the full unsigned 2*DW-bit result
  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
`endif

  // Opcode decode; ADD/SUB wrap naturally at DW bits
  always_comb begin
    o_lo   = '0;
    o_we_a = 1'b0;
`ifdef RF_EXEC_MUL_EN
    o_hi   = '0;
    o_we_b = 1'b0;
`endif
    case (i_op)
      OP_ADD: begin o_lo = i_a + i_b;        o_we_a = 1'b1; end
      OP_SUB: begin o_lo = i_a - i_b;        o_we_a = 1'b1; end
      OP_AND: begin o_lo = i_a & i_b;        o_we_a = 1'b1; end
      OP_OR:  begin o_lo = i_a | i_b;        o_we_a = 1'b1; end
      OP_XOR: begin o_lo = i_a ^ i_b;        o_we_a = 1'b1; end
      OP_SHL: begin o_lo = i_a << i_b[3:0];  o_we_a = 1'b1; end
      OP_SHR: begin o_lo = i_a >> i_b[3:0];  o_we_a = 1'b1; end
      OP_MOV: begin o_lo = i_a;              o_we_a = 1'b1; end
`ifdef RF_EXEC_MUL_EN
      OP_MUL: begin
        o_lo   = w_prod[DW-1:0];
        o_hi   = w_prod[2*DW-1:DW];
        o_we_a = 1'b1;
        o_we_b = 1'b1;
      end
`endif
      default: begin
        o_lo   = '0;
        o_we_a = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_exec_ctrl.sv
// -----------------------------------------------------------------------------
// rf_exec_ctrl
// Four-state execution controller: IDLE -> READ -> EXEC -> WB -> IDLE.
// Accepts one instruction, reads two registers, computes in rf_exec_alu and
// writes the result back three cycles after accept.
//   CLK, RST            : clock, synchronous active-high reset
//   i_bus (slave)       : instruction handshake (see rf_exec_if)
//   RAA/RAB, REA/REB    : register read addresses / enables (READ only)
//   RDA/RDB             : register read data, combinational from RAA/RAB
//   WAA/WDA/WEA         : primary write port (WB only)
//   WAB/WDB/WEB         : secondary write port (multiply high half)
//   BUSY                : controller not idle
//   DONE                : one-cycle pulse in WB
// Macro RF_EXEC_MUL_EN enables opcode 8 (unsigned multiply, two writes);
// without it opcode 8 is a no-op and the secondary port is tied to 0.
// -----------------------------------------------------------------------------
module rf_exec_ctrl
  import rf_exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  rf_exec_if.slave      i_bus,
  output logic [AW-1:0] RAA,
  output logic [AW-1:0] RAB,
  output logic          REA,
  output logic          REB,
  input  logic [DW-1:0] RDA,
  input  logic [DW-1:0] RDB,
  output logic [AW-1:0] WAA,
  output logic [DW-1:0] WDA,
  output logic          WEA,
  output logic [AW-1:0] WAB,
  output logic [DW-1:0] WDB,
  output logic          WEB,
  output logic          BUSY,
  output logic          DONE
);

  state_e        r_state;
  logic [3:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_result;
  logic          r_ready;
  logic          r_rd_en;
  logic          r_wea;
  logic          r_done;
  logic          r_busy;

  logic [DW-1:0] w_lo;
  logic          w_we_a;
  logic          w_in_ready;

`ifdef RF_EXEC_MUL_EN
  logic [DW-1:0] r_result_hi;
  logic          r_web;
  logic [DW-1:0] w_hi;
  logic          w_we_b;
`endif

  rf_exec_alu #(.DW(DW)) u_alu (
    .i_op   (r_op),
    .i_a    (r_opa),
    .i_b    (r_opb),
    .o_lo   (w_lo),
`ifdef RF_EXEC_MUL_EN
    .o_hi   (w_hi),
    .o_we_b (w_we_b),
`endif
    .o_we_a (w_we_a)
  );

  // r_ready is preset during reset so READY rises on the first post-reset
  // cycle; gating with RST keeps it low while reset is held.
  assign w_in_ready     = r_ready & ~RST;
  assign i_bus.IN_READY = w_in_ready;

  assign REA  = r_rd_en;
  assign REB  = r_rd_en;
  assign RAA  = r_rd_en ? r_rs1 : '0;
  assign RAB  = r_rd_en ? r_rs2 : '0;
  assign WEA  = r_wea;
  assign WAA  = r_wea ? r_rd : '0;
  assign WDA  = r_wea ? r_result : '0;
  assign BUSY = r_busy;
  assign DONE = r_done;

`ifdef RF_EXEC_MUL_EN
  assign WEB = r_web;
  assign WAB = r_web ? wb_hi_addr(r_rd) : '0;
  assign WDB = r_web ? r_result_hi : '0;
`else
  assign WEB = 1'b0;
  assign WAB = '0;
  assign WDB = '0;
`endif

  // Controller FSM with all flags registered alongside the state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_op        <= 4'd0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_ready     <= 1'b1;
      r_rd_en     <= 1'b0;
      r_wea       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef RF_EXEC_MUL_EN
      r_result_hi <= '0;
      r_web       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_bus.IN_VALID && w_in_ready) begin
            r_op    <= i_bus.IN_OP;
            r_rd    <= i_bus.IN_RD;
            r_rs1   <= i_bus.IN_RS1;
            r_rs2   <= i_bus.IN_RS2;
            r_ready <= 1'b0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_opa   <= RDA;
          r_opb   <= RDB;
          r_rd_en <= 1'b0;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result    <= w_lo;
          r_wea       <= w_we_a;
          r_done      <= 1'b1;
`ifdef RF_EXEC_MUL_EN
          r_result_hi <= w_hi;
          r_web       <= w_we_b;
`endif
          r_state     <= ST_WB;
        end
        ST_WB: begin
          r_wea   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
`ifdef RF_EXEC_MUL_EN
          r_web   <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
        default: begin
          r_rd_en <= 1'b0;
          r_wea   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
`ifdef RF_EXEC_MUL_EN
          r_web   <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
